// File: rtl/m_wb_uarttx_pkg.sv
// m_wb_uarttx_pkg
// Shared definitions for the Wishbone UART transmitter: serialiser state
// encoding, status register bit positions, register offsets and a helper
// that packs the status word.
// No ports (package).

package m_wb_uarttx_pkg;

  // Serialiser states; BUSY in the status word is simply "not idle".
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  // Status register bit positions.
  localparam int STAT_FULL      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_OVF       = 3;
  localparam int STAT_COUNT_LSB = 4;

  // Writing a 1 to this status bit clears the sticky overflow flag.
  localparam int OVF_CLEAR_BIT = 3;

  // Register offsets as seen on ADR_I.
  localparam logic REG_DATA   = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  // Packs the status word. The fill count is passed zero-extended so the
  // helper works for any FIFO depth; unused upper bits read as zero.
  function automatic logic [31:0] pack_status(
    input logic        full,
    input logic        empty,
    input logic        busy,
    input logic        ovf,
    input logic [27:0] count
  );
    logic [31:0] word;
    word                 = '0;
    word[STAT_FULL]      = full;
    word[STAT_EMPTY]     = empty;
    word[STAT_BUSY]      = busy;
    word[STAT_OVF]       = ovf;
    word[31:STAT_COUNT_LSB] = count;
    return word;
  endfunction

endpackage

// File: rtl/m_wb_uarttx_if.sv
// m_wb_uarttx_if
// Wishbone slave bus bundle for the UART transmitter. The parent has already
// decoded the address, so only a one-bit register select is carried.
// Signals:
//   STB_I  strobe             WE_I   write enable
//   SEL_I  byte selects       ADR_I  0 = data, 1 = status
//   DAT_I  write data         ACK_O  acknowledge
//   DAT_O  read data
// Modports: master (bus initiator), slave (the transmitter).

interface m_wb_uarttx_if;

  logic        STB_I;
  logic        WE_I;
  logic [3:0]  SEL_I;
  logic        ADR_I;
  logic [31:0] DAT_I;
  logic        ACK_O;
  logic [31:0] DAT_O;

  modport master (
    output STB_I, WE_I, SEL_I, ADR_I, DAT_I,
    input  ACK_O, DAT_O
  );

  modport slave (
    input  STB_I, WE_I, SEL_I, ADR_I, DAT_I,
    output ACK_O, DAT_O
  );

endinterface

// File: rtl/m_wb_uarttx_sfifo.sv
// m_sfifo
// Synchronous first-word-fall-through FIFO: dout always shows the oldest
// entry while the FIFO is non-empty.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   push, din push request and data (ignored when full)
//   pop       pop request (ignored when empty)
//   dout      head of the FIFO
//   full, empty, count  occupancy, evaluated before any same-edge push/pop

module m_sfifo #(
  parameter int WIDTH = 8,
  parameter int LOG2  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LOG2:0]    count
);

  localparam int          DEPTH     = 1 << LOG2;
  localparam logic [LOG2:0] DEPTH_CNT = (LOG2+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [LOG2-1:0]  wr_ptr;
  logic [LOG2-1:0]  rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Fullness is judged before a same-edge pop, so a pop never makes room
  // for a push on the same edge.
  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage has no reset; the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + LOG2'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + LOG2'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (LOG2+1)'(1);
        2'b01:   count <= count - (LOG2+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/m_wb_uarttx.sv
// m_wb_uarttx
// Wishbone slave UART transmitter (8N1, fixed baud divisor). Bytes written
// to the data register are queued in a FIFO and serialised onto TXD; the
// status register reports FIFO state, busy, sticky overflow and fill count.
// Ports:
//   CLK_I  system clock
//   RST_I  synchronous active-high reset
//   wb     Wishbone slave bundle (STB_I, WE_I, SEL_I, ADR_I, DAT_I, ACK_O, DAT_O)
//   TXD    serial output, idle high
//   irq    level: FIFO empty and serialiser idle

module m_wb_uarttx
  import m_wb_uarttx_pkg::*;
#(
  parameter int CLKDIV   = 104,
  parameter int DIVWIDTH = 16,
  parameter int FIFOLOG2 = 3
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  m_wb_uarttx_if.slave  wb,
  output logic          TXD,
  output logic          irq
);

  localparam logic [DIVWIDTH-1:0] DIV_RELOAD = DIVWIDTH'(CLKDIV - 1);

  tx_state_t           state;
  logic [DIVWIDTH-1:0] baud_cnt;
  logic [2:0]          bit_idx;
  logic [7:0]          shifter;
  logic                overflow;

  logic                fire;
  logic                push;
  logic                pop;
  logic                ovf_clear;
  logic                baud_done;
  logic [7:0]          fifo_dout;
  logic                fifo_full;
  logic                fifo_empty;
  logic [FIFOLOG2:0]   fifo_count;
  logic [31:0]         status;
  logic                unused_bits;

  // An access fires on the edge where the strobe is seen and no ack is
  // outstanding; a held strobe therefore fires every other cycle.
  assign fire      = wb.STB_I & ~wb.ACK_O;
  assign push      = fire & wb.WE_I & (wb.ADR_I == REG_DATA) & wb.SEL_I[0];
  assign ovf_clear = fire & wb.WE_I & (wb.ADR_I == REG_STATUS) & wb.SEL_I[0]
                     & wb.DAT_I[OVF_CLEAR_BIT];
  assign baud_done = (baud_cnt == '0);

  // The serialiser takes a byte either from idle or at the very end of a
  // stop bit, which is what makes consecutive frames run without a gap.
  assign pop = ~fifo_empty &
               ((state == ST_IDLE) | ((state == ST_STOP) & baud_done));

  assign status = pack_status(fifo_full, fifo_empty, state != ST_IDLE,
                              overflow, 28'(fifo_count));

  assign irq = fifo_empty & (state == ST_IDLE);

  assign unused_bits = ^{wb.SEL_I[3:1], wb.DAT_I[31:8]};

  m_sfifo #(
    .WIDTH (8),
    .LOG2  (FIFOLOG2)
  ) u_fifo (
    .clk   (CLK_I),
    .rst   (RST_I),
    .push  (push),
    .pop   (pop),
    .din   (wb.DAT_I[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Bus side: ack, registered read data and the sticky overflow flag. Read
  // data is only non-zero during the ack cycle of a status read.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      wb.ACK_O <= 1'b0;
      wb.DAT_O <= '0;
      overflow <= 1'b0;
    end else begin
      wb.ACK_O <= fire;
      if (fire & ~wb.WE_I & (wb.ADR_I == REG_STATUS)) begin
        wb.DAT_O <= status;
      end else begin
        wb.DAT_O <= '0;
      end
      if (push & fifo_full) begin
        overflow <= 1'b1;
      end else if (ovf_clear) begin
        overflow <= 1'b0;
      end
    end
  end

  // 8N1 serialiser. Every state holds its TXD level for CLKDIV cycles: the
  // counter is loaded with CLKDIV-1 on entry and the bit advances once it
  // has counted down to zero.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state    <= ST_IDLE;
      TXD      <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shifter  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            shifter  <= fifo_dout;
            TXD      <= 1'b0;
            baud_cnt <= DIV_RELOAD;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (!baud_done) begin
            baud_cnt <= baud_cnt - DIVWIDTH'(1);
          end else begin
            TXD      <= shifter[0];
            baud_cnt <= DIV_RELOAD;
            bit_idx  <= '0;
            state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (!baud_done) begin
            baud_cnt <= baud_cnt - DIVWIDTH'(1);
          end else if (bit_idx == 3'd7) begin
            TXD      <= 1'b1;
            baud_cnt <= DIV_RELOAD;
            state    <= ST_STOP;
          end else begin
            // shifter[0] is on the line; the next bit comes from shifter[1].
            TXD      <= shifter[1];
            shifter  <= {1'b0, shifter[7:1]};
            bit_idx  <= bit_idx + 3'd1;
            baud_cnt <= DIV_RELOAD;
          end
        end
        ST_STOP: begin
          if (!baud_done) begin
            baud_cnt <= baud_cnt - DIVWIDTH'(1);
          end else if (!fifo_empty) begin
            shifter  <= fifo_dout;
            TXD      <= 1'b0;
            baud_cnt <= DIV_RELOAD;
            state    <= ST_START;
          end else begin
            state    <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          TXD   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/m_wb_uarttx.md
Name: m_wb_uarttx

Overview:
Wishbone-slave UART transmitter that sits directly downstream of the midgetv core data bus, beside the register peripheral in the ice40 simulation top. The core writes bytes into a small FIFO. An 8N1 serialiser drains the FIFO onto TXD at a fixed baud divisor. Status is readable over the same bus, and a level interrupt reports "all sent".

Parameters:
CLKDIV, 104, clock cycles per bit (must be >= 2; 12 MHz / 115200).
DIVWIDTH, 16, width of baud counter (must hold CLKDIV-1).
FIFOLOG2, 3, log2 of FIFO depth (depth 8 at default).

Ports:
CLK_I  in  1  single system clock.
RST_I  in  1  synchronous, active-high reset.
STB_I  in  1  Wishbone strobe, already address-decoded by parent.
WE_I  in  1  Wishbone write enable.
SEL_I  in  4  byte selects; only SEL_I[0] is used.
ADR_I  in  1  register select: 0 = data, 1 = status (parent drives ADR_O[2]).
DAT_I  in  32  write data.
ACK_O  out  1  Wishbone acknowledge.
DAT_O  out  32  read data.
TXD  out  1  serial output, idle high.
irq  out  1  level: FIFO empty and serialiser idle.

Behaviour:
- Reset values (next edge with RST_I=1): ACK_O=0, DAT_O=0, TXD=1, FIFO empty, overflow=0, FSM=IDLE, baud counter=0. irq=1 after reset.
- Reset mid-frame: TXD returns to 1 on that edge. FIFO contents are discarded.
- Handshake: ACK_O <= STB_I & ~ACK_O.
  - Every access is acked one cycle after STB_I is sampled.
  - A held STB_I gives ACK on alternate cycles.
  - An access "fires" on the edge where STB_I & ~ACK_O is true.
- Data write (fire, WE_I, ADR_I=0, SEL_I[0]): push DAT_I[7:0].
  - If the FIFO is full at that edge, the byte is dropped and overflow is set (sticky).
  - A pop on the same edge does not make room: fullness is evaluated before the pop.
- Status write (ADR_I=1, SEL_I[0], DAT_I[3]=1): clears overflow.
- Reads: DAT_O is registered on the fire edge and valid while ACK_O=1. DAT_O=0 otherwise.
  - ADR_I=0 reads 0.
  - ADR_I=1 status layout: [0] full, [1] empty, [2] busy (FSM != IDLE), [3] overflow, [4+FIFOLOG2:4] fill count, rest 0.
- FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: when the FIFO is non-empty, pop into an 8-bit shifter, TXD<=0, load the counter with CLKDIV-1, go to START.
  - Each state holds its TXD level for exactly CLKDIV cycles. The counter decrements to 0, then the bit advances.
  - START: -> DATA with TXD = shifter[0].
  - DATA: 8 bits, LSB first, with a 3-bit bit index. After bit 7 -> STOP with TXD=1.
  - STOP: lasts CLKDIV cycles. At its end, if the FIFO is non-empty, pop directly and go to START (no idle gap). Otherwise go to IDLE.
- Timing: a write firing at edge N into an empty FIFO while idle drives TXD low at edge N+2. A frame is 10*CLKDIV cycles.
- Fill count: increments on push, decrements on pop, unchanged on simultaneous accepted push and pop. Read/write pointers wrap modulo depth.
- irq = empty & (FSM==IDLE), combinational from registers.

Decomposition:
- Shared header (localparams): FSM state encodings, status bit indices, register offsets.
- One sub-module: m_sfifo, a synchronous FIFO parameterised by width (8) and FIFOLOG2, with ports push, pop, din, dout, full, empty, count. The FIFO is first-word-fall-through.
- Baud counter, FSM and bus logic stay in m_wb_uarttx.

Test Plan (CLKDIV=4, FIFOLOG2=2):
1. Reset, then hold RST_I=1 for 1 cycle -> TXD=1, ACK_O=0, irq=1, status read = 0x02.
2. Write 0x55 to data at edge N -> ACK_O=1 at N+1; TXD=0 at N+2 for 4 cycles; then bits 1,0,1,0,1,0,1,0 at 4 cycles each; then stop=1; irq=1 at N+42.
3. Write 0xA1, 0x02 back-to-back -> second frame's start bit immediately follows the first stop bit (no idle cycles); bytes appear LSB first in order.
4. With TXD busy, write 6 bytes -> 1 popped, FIFO holds 4, 1 dropped; status = full|busy|overflow with count 4 (0x4D). Write 0x08 to status -> overflow clears.
5. Hold STB_I high for 6 cycles on a status read -> ACK_O pattern 0,1,0,1,0,1; DAT_O=0 whenever ACK_O=0.
6. Assert RST_I mid data bit of a frame with 2 bytes queued -> TXD=1 next edge, status=0x02, no further frames are emitted.
